ads8528_par_model: RTL and testbench

Synthesizable responder for the ADS8528 parallel interface: the ADC end of the link that the ADC driver controls. It accepts the driver's configuration writes and CONVST/RD_N/CS_N strobes, raises Busy for a programmable conversion time, and returns latched channel samples on the data bus. It sits in the FPGA loopback build and the simulation bench in place of the real ADC, so the driver and the downstream memory path can be exercised without the board.

---
 rtl/ads8528_pkg.sv | 52 +++++
 rtl/ads8528_pin_edge.sv | 30 +++
 rtl/ads8528_par_model.sv | 206 ++++++++++++++++++++
 tb/tb_ads8528_par_model.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ads8528_pkg.sv
// Shared constants, state type and channel-walk helpers for the ADS8528 parallel-port responder.
package ads8528_pkg;

  localparam logic [2:0] CH_A0 = 3'd0;
  localparam logic [2:0] CH_A1 = 3'd1;
  localparam logic [2:0] CH_B0 = 3'd2;
  localparam logic [2:0] CH_B1 = 3'd3;
  localparam logic [2:0] CH_C0 = 3'd4;
  localparam logic [2:0] CH_C1 = 3'd5;
  localparam logic [2:0] CH_D0 = 3'd6;
  localparam logic [2:0] CH_D1 = 3'd7;

  localparam int N_CH  = 8;
  localparam int SMP_W = 16;

  localparam int CFG_UPDATE = 31;
  localparam int CFG_PD_B   = 22;
  localparam int CFG_PD_C   = 20;
  localparam int CFG_PD_D   = 18;

  localparam logic [31:0] CFG_DEFAULT = 32'h0000_03FF;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    READY
  } state_t;

  // Pair A can never be powered down, so its enable is tied high.
  function automatic logic [3:0] pair_enables(input logic pd_b, input logic pd_c,
                                              input logic pd_d);
    return {~pd_d, ~pd_c, ~pd_b, 1'b1};
  endfunction

  // First enabled channel above cur; wraps to A0 when none remain.
  function automatic logic [2:0] next_idx(input logic [2:0] cur, input logic [3:0] en);
    logic [2:0] nxt;
    logic [2:0] cand;
    logic       found;
    nxt   = CH_A0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      cand = 3'(i);
      if (!found && (cand > cur) && en[cand[2:1]]) begin
        nxt   = cand;
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ads8528_pin_edge.sv
// One-stage input register plus previous-value register; rise/fall pulse on the compare.
module ads8528_pin_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_sync <= i_pin;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/ads8528_par_model.sv
// ADC-side responder for the ADS8528 parallel interface: config writes, timed Busy,
// and readback of latched channel samples in enabled-channel order.
module ads8528_par_model
  import ads8528_pkg::*;
#(
  parameter int CONV_CYCLES = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         convst_A,
  input  logic         convst_B,
  input  logic         convst_C,
  input  logic         convst_D,
  input  logic         CS_N,
  input  logic         RD_N,
  input  logic         WR_N,
  input  logic         HW_N,
  input  logic         PAR_N,
  input  logic         STBY_N,
  input  logic [127:0] ch_data,
  input  logic [15:0]  db_i,
  output logic [15:0]  db_o,
  output logic         db_oe,
  output logic         Busy,
  output logic [31:0]  config_q,
  output logic [2:0]   rd_idx
);

  localparam logic [7:0] LP_CONV = 8'(CONV_CYCLES);

  logic [3:0] w_cv_pins;
  logic [3:0] w_cv_level;
  logic [3:0] w_cv_rise;
  logic [3:0] w_cv_fall;
  logic       w_cs_level, w_cs_rise, w_cs_fall;
  logic       w_rd_level, w_rd_rise, w_rd_fall;
  logic       w_wr_level, w_wr_rise, w_wr_fall;
  logic       w_unused_edges;

  assign w_cv_pins = {convst_D, convst_C, convst_B, convst_A};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_convst
      ads8528_pin_edge #(.RST_VAL(1'b0)) u_edge (
        .clk    (clk),
        .rst    (rst),
        .i_pin  (w_cv_pins[gi]),
        .o_level(w_cv_level[gi]),
        .o_rise (w_cv_rise[gi]),
        .o_fall (w_cv_fall[gi])
      );
    end
  endgenerate

  ads8528_pin_edge #(.RST_VAL(1'b1)) u_cs_edge (
    .clk    (clk),
    .rst    (rst),
    .i_pin  (CS_N),
    .o_level(w_cs_level),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  ads8528_pin_edge #(.RST_VAL(1'b1)) u_rd_edge (
    .clk    (clk),
    .rst    (rst),
    .i_pin  (RD_N),
    .o_level(w_rd_level),
    .o_rise (w_rd_rise),
    .o_fall (w_rd_fall)
  );

  ads8528_pin_edge #(.RST_VAL(1'b1)) u_wr_edge (
    .clk    (clk),
    .rst    (rst),
    .i_pin  (WR_N),
    .o_level(w_wr_level),
    .o_rise (w_wr_rise),
    .o_fall (w_wr_fall)
  );

  assign w_unused_edges = ^{w_cv_level, w_cv_fall, w_cs_fall, w_rd_level, w_wr_level, w_wr_fall};

  state_t      r_state;
  logic [7:0]  r_count;
  logic [31:0] r_config;
  logic [15:0] r_hold;
  logic        r_wr_ptr;
  logic [15:0] r_conv_smp [N_CH];
  logic [15:0] r_rd_smp   [N_CH];
  logic [15:0] r_db_o;
  logic        r_db_oe;
  logic        r_rd_adv;
  logic [2:0]  r_rd_idx;

  logic        w_mode_ok;
  logic        w_cs_low;
  logic        w_busy;
  logic [3:0]  w_pair_en;
  logic        w_conv_start;
  logic        w_conv_done;
  logic        w_wr_acc;
  logic        w_rd_start;
  logic [31:0] w_cfg_word;

  assign w_mode_ok    = HW_N & ~PAR_N & STBY_N;
  assign w_cs_low     = ~w_cs_level;
  assign w_busy       = (r_state == CONV);
  assign w_pair_en    = pair_enables(r_config[CFG_PD_B], r_config[CFG_PD_C], r_config[CFG_PD_D]);
  assign w_conv_start = (r_state != CONV) && STBY_N && (|(w_cv_rise & w_pair_en));
  assign w_conv_done  = (r_state == CONV) && (r_count == 8'd1);
  assign w_wr_acc     = w_wr_rise & w_cs_low & w_mode_ok;
  // A write edge in the same cycle as a read-start edge takes priority.
  assign w_rd_start   = w_rd_fall & w_cs_low & w_mode_ok & ~w_wr_acc;
  assign w_cfg_word   = {r_hold, db_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
    end else if (!STBY_N) begin
      r_state <= IDLE;
      r_count <= '0;
    end else if (w_conv_start) begin
      r_state <= CONV;
      r_count <= LP_CONV;
    end else if (w_conv_done) begin
      r_state <= READY;
      r_count <= '0;
    end else if (r_state == CONV) begin
      r_count <= r_count - 8'd1;
    end
  end

  // Fresh samples are only published to the read side once Busy falls,
  // so reads during a conversion return the previous result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        r_conv_smp[i] <= '0;
        r_rd_smp[i]   <= '0;
      end
    end else begin
      if (w_conv_start) begin
        for (int i = 0; i < N_CH; i++) begin
          r_conv_smp[i] <= ch_data[i*SMP_W +: SMP_W];
        end
      end
      if (w_conv_done && STBY_N) begin
        for (int i = 0; i < N_CH; i++) begin
          r_rd_smp[i] <= r_conv_smp[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_config <= CFG_DEFAULT;
      r_hold   <= '0;
      r_wr_ptr <= 1'b0;
    end else if (w_wr_acc) begin
      r_wr_ptr <= ~r_wr_ptr;
      if (!r_wr_ptr) begin
        r_hold <= db_i;
      end else if (w_cfg_word[CFG_UPDATE]) begin
        r_config <= w_cfg_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_o   <= '0;
      r_db_oe  <= 1'b0;
      r_rd_adv <= 1'b0;
    end else if (!w_mode_ok) begin
      r_db_oe <= 1'b0;
    end else if (w_rd_start) begin
      r_db_o   <= r_rd_smp[r_rd_idx];
      r_db_oe  <= 1'b1;
      r_rd_adv <= ~w_busy;
    end else if (w_rd_rise || w_cs_rise) begin
      r_db_oe <= 1'b0;
    end
  end

  // A conversion start overrides any read completing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_idx <= CH_A0;
    end else if (w_conv_start) begin
      r_rd_idx <= CH_A0;
    end else if (w_rd_rise && w_mode_ok && r_db_oe && r_rd_adv) begin
      r_rd_idx <= next_idx(r_rd_idx, w_pair_en);
    end
  end

  assign db_o     = r_db_o;
  assign db_oe    = r_db_oe;
  assign Busy     = w_busy;
  assign config_q = r_config;
  assign rd_idx   = r_rd_idx;

endmodule

// File: tb/tb_ads8528_par_model.sv
// Directed plus randomized bench for ads8528_par_model against a list-based reference model.
module tb_ads8528_par_model;

  localparam int CONV = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   cv;
  logic         CS_N, RD_N, WR_N, HW_N, PAR_N, STBY_N;
  logic [127:0] ch_data;
  logic [15:0]  db_i;
  logic [15:0]  db_o;
  logic         db_oe;
  logic         Busy;
  logic [31:0]  config_q;
  logic [2:0]   rd_idx;

  ads8528_par_model #(.CONV_CYCLES(CONV)) dut (
    .clk     (clk),
    .rst     (rst),
    .convst_A(cv[0]),
    .convst_B(cv[1]),
    .convst_C(cv[2]),
    .convst_D(cv[3]),
    .CS_N    (CS_N),
    .RD_N    (RD_N),
    .WR_N    (WR_N),
    .HW_N    (HW_N),
    .PAR_N   (PAR_N),
    .STBY_N  (STBY_N),
    .ch_data (ch_data),
    .db_i    (db_i),
    .db_o    (db_o),
    .db_oe   (db_oe),
    .Busy    (Busy),
    .config_q(config_q),
    .rd_idx  (rd_idx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: config word, published samples, enabled-channel list, next read channel.
  logic [31:0] m_cfg;
  logic [15:0] m_smp [8];
  logic [15:0] pend  [8];
  int          m_list[$];
  int          m_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void build_list();
    m_list.delete();
    for (int ch = 0; ch < 8; ch++) begin
      int pair;
      pair = ch / 2;
      if (pair == 0 || !m_cfg[24 - 2*pair]) m_list.push_back(ch);
    end
  endfunction

  function automatic void model_reset();
    m_cfg = 32'h0000_03FF;
    for (int i = 0; i < 8; i++) m_smp[i] = 16'h0000;
    m_idx = 0;
    build_list();
  endfunction

  function automatic void snapshot();
    for (int i = 0; i < 8; i++) pend[i] = ch_data[16*i +: 16];
  endfunction

  function automatic void publish();
    for (int i = 0; i < 8; i++) m_smp[i] = pend[i];
  endfunction

  task automatic wr_word(input logic [15:0] d);
    db_i = d;
    WR_N = 1'b0;
    tick(3);
    WR_N = 1'b1;
    tick(3);
    $display("write word 0x%04h", d);
  endtask

  task automatic wr_pair(input logic [15:0] hi, input logic [15:0] lo);
    wr_word(hi);
    wr_word(lo);
    if (hi[15]) m_cfg = {hi, lo};
    build_list();
  endtask

  task automatic do_read(input string tag);
    logic [15:0] exp;
    int          nxt;
    exp = m_smp[m_idx];
    check({tag, "_idx"}, 32'(rd_idx), 32'(m_idx));
    RD_N = 1'b0;
    tick(3);
    check({tag, "_oe"}, 32'(db_oe), 32'd1);
    check({tag, "_data"}, 32'(db_o), 32'(exp));
    RD_N = 1'b1;
    tick(3);
    check({tag, "_oe_off"}, 32'(db_oe), 32'd0);
    $display("read %s ch=%0d data=0x%04h", tag, m_idx, db_o);
    nxt = 0;
    foreach (m_list[k]) begin
      if (m_list[k] > m_idx) begin
        nxt = m_list[k];
        break;
      end
    end
    m_idx = nxt;
  endtask

  task automatic run_conv(input string tag, input int pair);
    bit en;
    int busy;
    en = (pair == 0) || !m_cfg[24 - 2*pair];
    snapshot();
    busy = 0;
    cv[pair] = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (c == 2) cv[pair] = 1'b0;
      if (Busy) busy++;
      else if (busy > 0) break;
    end
    check({tag, "_busy_len"}, 32'(busy), en ? 32'(CONV) : 32'd0);
    $display("conv %s pair=%0d busy_cycles=%0d", tag, pair, busy);
    if (en) begin
      publish();
      m_idx = 0;
    end
  endtask

  initial begin
    int busy;
    int oe_seen;
    bit reached;
    logic [15:0] old0;
    logic [15:0] hi, lo;
    int pair;

    rst = 1'b1; cv = '0; CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
    HW_N = 1'b1; PAR_N = 1'b0; STBY_N = 1'b1; db_i = '0; ch_data = '0;
    model_reset();
    tick(3);
    rst = 1'b0;
    CS_N = 1'b0;
    tick(3);

    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_oe", 32'(db_oe), 32'd0);
    check("rst_db_o", 32'(db_o), 32'd0);
    check("rst_cfg", config_q, 32'h0000_03FF);
    check("rst_idx", 32'(rd_idx), 32'd0);

    do_read("pre_conv");

    // Default config: all eight channels walk in order and wrap.
    for (int i = 0; i < 8; i++) ch_data[16*i +: 16] = 16'(16'h0101 * (i + 1));
    run_conv("ramp", 0);
    for (int r = 0; r < 9; r++) do_read($sformatf("ramp%0d", r));

    wr_pair(16'h0054, 16'h03FF);
    check("cfg_discard", config_q, 32'h0000_03FF);

    wr_pair(16'h8054, 16'h03FF);
    check("cfg_update", config_q, 32'h8054_03FF);

    for (int i = 0; i < 4; i++) ch_data[32*i +: 32] = $urandom;
    ch_data[15:0]  = 16'h1111;
    ch_data[31:16] = 16'h2222;
    run_conv("pd_b", 1);
    run_conv("a_only", 0);
    for (int r = 0; r < 3; r++) do_read($sformatf("a_only%0d", r));

    for (int it = 0; it < 4; it++) begin
      hi = {1'b1, 15'($urandom)};
      lo = 16'($urandom);
      wr_pair(hi, lo);
      check($sformatf("cfg_rand%0d", it), config_q, m_cfg);
      for (int i = 0; i < 4; i++) ch_data[32*i +: 32] = $urandom;
      pair = m_list[$urandom_range(0, m_list.size() - 1)] / 2;
      run_conv($sformatf("rand%0d", it), pair);
      for (int r = 0; r <= m_list.size(); r++) do_read($sformatf("rand%0d_%0d", it, r));
    end

    // Second convst and a read while busy: ignored edge, stale data, no index advance.
    old0 = m_smp[0];
    for (int i = 0; i < 4; i++) ch_data[32*i +: 32] = $urandom;
    snapshot();
    busy = 0;
    cv[0] = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (c == 2) cv[0] = 1'b0;
      if (Busy) busy++;
      else if (busy > 0) break;
      if (Busy && busy == 5) cv[0] = 1'b1;
      if (Busy && busy == 8) cv[0] = 1'b0;
      if (Busy && busy == 12) RD_N = 1'b0;
      if (Busy && busy == 16) begin
        check("busy_rd_oe", 32'(db_oe), 32'd1);
        check("busy_rd_stale", 32'(db_o), 32'(old0));
        RD_N = 1'b1;
      end
      if (Busy && busy == 20) begin
        check("busy_rd_oe_off", 32'(db_oe), 32'd0);
        check("busy_rd_idx", 32'(rd_idx), 32'd0);
      end
    end
    check("busy_ignore_len", 32'(busy), 32'(CONV));
    $display("conv busy_interference busy_cycles=%0d", busy);
    publish();
    m_idx = 0;
    do_read("after_busy");

    // Reset in the middle of a conversion with a read in progress.
    for (int i = 0; i < 4; i++) ch_data[32*i +: 32] = $urandom;
    busy = 0;
    reached = 1'b0;
    cv[0] = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 2) cv[0] = 1'b0;
      if (Busy) busy++;
      if (busy == 4) RD_N = 1'b0;
      if (busy == 8) begin
        check("rstmid_oe_before", 32'(db_oe), 32'd1);
        check("rstmid_stale", 32'(db_o), 32'(m_smp[0]));
      end
      if (busy == 10) begin
        rst = 1'b1;
        RD_N = 1'b1;
        reached = 1'b1;
        break;
      end
    end
    check("rstmid_reached", 32'(reached), 32'd1);
    @(negedge clk);
    check("rstmid_busy", 32'(Busy), 32'd0);
    check("rstmid_oe", 32'(db_oe), 32'd0);
    check("rstmid_cfg", config_q, 32'h0000_03FF);
    check("rstmid_idx", 32'(rd_idx), 32'd0);
    rst = 1'b0;
    model_reset();
    $display("reset mid-conversion at busy cycle %0d", busy);
    tick(3);
    do_read("after_rst");

    // Standby mid-conversion aborts it; the aborted samples are never published.
    for (int i = 0; i < 4; i++) ch_data[32*i +: 32] = $urandom;
    run_conv("pre_stby", 0);
    for (int i = 0; i < 4; i++) ch_data[32*i +: 32] = $urandom;
    busy = 0;
    reached = 1'b0;
    cv[0] = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 2) cv[0] = 1'b0;
      if (Busy) busy++;
      if (busy == 15) begin
        STBY_N = 1'b0;
        reached = 1'b1;
        break;
      end
    end
    check("stby_reached", 32'(reached), 32'd1);
    m_idx = 0;
    @(negedge clk);
    check("stby_busy", 32'(Busy), 32'd0);
    tick(3);
    check("stby_busy_hold", 32'(Busy), 32'd0);
    STBY_N = 1'b1;
    tick(3);
    check("stby_idle", 32'(Busy), 32'd0);
    $display("standby during conversion at busy cycle %0d", busy);
    do_read("after_stby");

    // Invalid mode: read strobes never drive the bus and writes are dropped.
    PAR_N = 1'b1;
    tick(2);
    oe_seen = 0;
    RD_N = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (db_oe) oe_seen++;
    end
    RD_N = 1'b1;
    tick(3);
    check("parn_no_oe", 32'(oe_seen), 32'd0);
    wr_word(16'h8000);
    wr_word(16'h0000);
    check("parn_no_write", config_q, m_cfg);
    PAR_N = 1'b0;
    $display("invalid mode PAR_N=1 oe_cycles=%0d", oe_seen);
    tick(2);
    do_read("after_parn");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
